// File: rtl/wb_pipe_reg.sv
// Writeback pipeline register: a chain of DEPTH slots carrying memory-stage results into W,
// plus a combinational forwarding lookup over every in-flight slot.
module wb_pipe_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W = 5,
    parameter int unsigned DEPTH = 1,
    parameter logic [REG_W-1:0] NONE_REG = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              bubble,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [DATA_W-1:0] m_valM,
    input  logic [REG_W-1:0]  M_dstE,
    input  logic [REG_W-1:0]  M_dstM,
    output logic              W_valid,
    output logic [DATA_W-1:0] W_valE,
    output logic [DATA_W-1:0] W_valM,
    output logic [REG_W-1:0]  W_dstE,
    output logic [REG_W-1:0]  W_dstM,
    input  logic [REG_W-1:0]  fwd_src,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_val
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] valE;
        logic [DATA_W-1:0] valM;
        logic [REG_W-1:0]  dstE;
        logic [REG_W-1:0]  dstM;
    } slot_t;

    localparam slot_t NOP_SLOT = '{valid: 1'b0, valE: '0, valM: '0, dstE: NONE_REG, dstM: NONE_REG};

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : gBadDepth
            $fatal(1, "wb_pipe_reg: DEPTH must be in 1..4");
        end
    endgenerate

    slot_t slots [DEPTH];
    slot_t slotIn;

    // Value entering slot 0 when the chain advances; bubble beats a real instruction.
    always_comb begin
        slotIn = NOP_SLOT;
        if (!bubble && in_valid) begin
            slotIn = '{valid: 1'b1, valE: M_valE, valM: m_valM, dstE: M_dstE, dstM: M_dstM};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slots[i] <= NOP_SLOT;
            end
        end else if (!stall) begin
            slots[0] <= slotIn;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                slots[i] <= slots[i-1];
            end
        end
    end

    assign W_valid = slots[DEPTH-1].valid;
    assign W_valE  = slots[DEPTH-1].valE;
    assign W_valM  = slots[DEPTH-1].valM;
    assign W_dstE  = slots[DEPTH-1].dstE;
    assign W_dstM  = slots[DEPTH-1].dstM;

    // Walk oldest to youngest so the youngest match is the last one written; dstM beats dstE.
    always_comb begin
        fwd_hit = 1'b0;
        fwd_val = '0;
        if (fwd_src != NONE_REG) begin
            for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
                if (slots[i].valid) begin
                    if (slots[i].dstM == fwd_src) begin
                        fwd_hit = 1'b1;
                        fwd_val = slots[i].valM;
                    end else if (slots[i].dstE == fwd_src) begin
                        fwd_hit = 1'b1;
                        fwd_val = slots[i].valE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Directed bench for wb_pipe_reg: a DEPTH=1 and a DEPTH=3 instance share one stimulus stream.
module tb_wb_pipe_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        bubble;
    logic        in_valid;
    logic [31:0] M_valE;
    logic [31:0] m_valM;
    logic [4:0]  M_dstE;
    logic [4:0]  M_dstM;
    logic [4:0]  fwd_src;

    logic        w1Valid, w3Valid, f1Hit, f3Hit;
    logic [31:0] w1ValE, w1ValM, w3ValE, w3ValM, f1Val, f3Val;
    logic [4:0]  w1DstE, w1DstM, w3DstE, w3DstM;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_pipe_reg #(.DATA_W(32), .REG_W(5), .DEPTH(1), .NONE_REG(5'd0)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .bubble(bubble), .in_valid(in_valid),
        .M_valE(M_valE), .m_valM(m_valM), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .W_valid(w1Valid), .W_valE(w1ValE), .W_valM(w1ValM), .W_dstE(w1DstE), .W_dstM(w1DstM),
        .fwd_src(fwd_src), .fwd_hit(f1Hit), .fwd_val(f1Val)
    );

    wb_pipe_reg #(.DATA_W(32), .REG_W(5), .DEPTH(3), .NONE_REG(5'd0)) dut3 (
        .clk(clk), .rst(rst), .stall(stall), .bubble(bubble), .in_valid(in_valid),
        .M_valE(M_valE), .m_valM(m_valM), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .W_valid(w3Valid), .W_valE(w3ValE), .W_valM(w3ValM), .W_dstE(w3DstE), .W_dstM(w3DstM),
        .fwd_src(fwd_src), .fwd_hit(f3Hit), .fwd_val(f3Val)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] e, input logic [31:0] m,
                         input logic [4:0] de, input logic [4:0] dm);
        in_valid = v;
        M_valE = e;
        m_valM = m;
        M_dstE = de;
        M_dstM = dm;
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        bubble = 1'b0;
        fwd_src = 5'd3;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_w1_valid", 32'(w1Valid), 32'h0);
        chk("rst_w3_valid", 32'(w3Valid), 32'h0);
        chk("rst_w3_valE", w3ValE, 32'h0);
        chk("rst_w3_dstE", 32'(w3DstE), 32'h0);
        chk("rst_f3_hit", 32'(f3Hit), 32'h0);
        chk("rst_f3_val", f3Val, 32'h0);

        // Streaming 1..7: DEPTH=1 shows k after one edge, DEPTH=3 shows k-2
        for (int k = 1; k <= 7; k++) begin
            drive(1'b1, 32'(k), 32'(k), 5'(k), 5'(k));
            step();
            chk("str_w1_valid", 32'(w1Valid), 32'h1);
            chk("str_w1_valE", w1ValE, 32'(k));
            chk("str_w1_valM", w1ValM, 32'(k));
            chk("str_w1_dstE", 32'(w1DstE), 32'(k));
            chk("str_w1_dstM", 32'(w1DstM), 32'(k));
            if (k >= 3) begin
                chk("str_w3_valE", w3ValE, 32'(k - 2));
                chk("str_w3_valid", 32'(w3Valid), 32'h1);
            end
        end

        // Forwarding across in-flight slots: dut3 holds 7,6,5
        fwd_src = 5'd6;
        #1;
        chk("fwd_mid_hit", 32'(f3Hit), 32'h1);
        chk("fwd_mid_val", f3Val, 32'h6);
        fwd_src = 5'd4;
        #1;
        chk("fwd_gone_hit", 32'(f3Hit), 32'h0);
        fwd_src = 5'd7;
        #1;
        chk("fwd_d1_hit", 32'(f1Hit), 32'h1);
        chk("fwd_d1_val", f1Val, 32'h7);

        // stall overrides bubble and in_valid
        drive(1'b1, 32'h99, 32'h99, 5'd9, 5'd9);
        stall = 1'b1;
        bubble = 1'b1;
        step();
        step();
        chk("stall_w1_valE", w1ValE, 32'h7);
        chk("stall_w3_valE", w3ValE, 32'h5);
        chk("stall_w3_valid", 32'(w3Valid), 32'h1);

        // bubble overrides in_valid and drains the chain
        stall = 1'b0;
        step();
        chk("bub_w1_valid", 32'(w1Valid), 32'h0);
        chk("bub_w1_dstE", 32'(w1DstE), 32'h0);
        chk("bub_w3_valE1", w3ValE, 32'h6);
        step();
        chk("bub_w3_valE2", w3ValE, 32'h7);
        step();
        chk("bub_w3_valid", 32'(w3Valid), 32'h0);
        chk("bub_w3_dstE", 32'(w3DstE), 32'h0);
        chk("bub_w3_dstM", 32'(w3DstM), 32'h0);
        bubble = 1'b0;

        // DEPTH=3 latency
        drive(1'b1, 32'hA5, 32'h0, 5'd1, 5'd0);
        step();
        chk("lat_w1_valE", w1ValE, 32'hA5);
        chk("lat_e0_valid", 32'(w3Valid), 32'h0);
        drive(1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
        step();
        chk("lat_e1_valid", 32'(w3Valid), 32'h0);
        step();
        chk("lat_e2_valid", 32'(w3Valid), 32'h1);
        chk("lat_e2_valE", w3ValE, 32'hA5);
        step();
        chk("lat_e3_valid", 32'(w3Valid), 32'h0);
        chk("lat_e3_valE", w3ValE, 32'h0);

        // Forwarding priority: youngest slot wins, then dstM beats dstE
        drive(1'b1, 32'h0, 32'h22, 5'd0, 5'd5);
        step();
        drive(1'b1, 32'h11, 32'h0, 5'd5, 5'd0);
        step();
        fwd_src = 5'd5;
        #1;
        chk("fwd_young_hit", 32'(f3Hit), 32'h1);
        chk("fwd_young_val", f3Val, 32'h11);
        drive(1'b1, 32'h33, 32'h44, 5'd5, 5'd5);
        step();
        chk("fwd_ldm_val", f3Val, 32'h44);
        chk("fwd_ldm_d1_val", f1Val, 32'h44);

        // Exclusions: NONE_REG never forwards, M inputs are not searched
        fwd_src = 5'd0;
        #1;
        chk("fwd_none_hit", 32'(f3Hit), 32'h0);
        chk("fwd_none_val", f3Val, 32'h0);
        drive(1'b0, 32'h55, 32'h55, 5'd9, 5'd9);
        fwd_src = 5'd9;
        #1;
        chk("fwd_noM_hit", 32'(f3Hit), 32'h0);
        bubble = 1'b1;
        step();
        step();
        step();
        bubble = 1'b0;
        fwd_src = 5'd5;
        #1;
        chk("fwd_inval_hit", 32'(f3Hit), 32'h0);
        chk("fwd_inval_val", f3Val, 32'h0);

        // Asynchronous reset with a full chain
        drive(1'b1, 32'h77, 32'h78, 5'd3, 5'd3);
        step();
        step();
        step();
        chk("full_w3_valid", 32'(w3Valid), 32'h1);
        chk("full_w3_valE", w3ValE, 32'h77);
        fwd_src = 5'd3;
        #3;
        rst = 1'b1;
        #1;
        chk("arst_w3_valid", 32'(w3Valid), 32'h0);
        chk("arst_w3_valE", w3ValE, 32'h0);
        chk("arst_w3_dstE", 32'(w3DstE), 32'h0);
        chk("arst_f3_hit", 32'(f3Hit), 32'h0);
        chk("arst_w1_valid", 32'(w1Valid), 32'h0);
        chk("arst_f1_hit", 32'(f1Hit), 32'h0);
        step();
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_pipe_reg.md
Name: wb_pipe_reg

Overview:
Parametrised successor to the single-stage writeback pipeline register. It carries the memory-stage results (valE, valM, dstE, dstM) into the writeback stage through a configurable chain of DEPTH register slots, for multi-cycle memory paths. It supports stall (hold), bubble (NOP injection), a per-slot valid bit and asynchronous reset. It also provides a combinational forwarding lookup across all in-flight slots for the decode-stage hazard unit.

Parameters:
DATA_W, 32, width of valE/valM
REG_W, 5, width of register specifiers dstE/dstM
DEPTH, 1, number of register slots (legal 1..4); slot 0 is written from M, slot DEPTH-1 drives W
NONE_REG, 0, register specifier meaning "no write" ($0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
stall  in  1  hold all slots this cycle
bubble  in  1  load a NOP into slot 0 this cycle
in_valid  in  1  M-stage result is a real instruction
M_valE  in  DATA_W  ALU result from M
m_valM  in  DATA_W  memory read data from M
M_dstE  in  REG_W  destination for valE
M_dstM  in  REG_W  destination for valM
W_valid  out  1  slot DEPTH-1 holds a real instruction
W_valE  out  DATA_W  writeback valE
W_valM  out  DATA_W  writeback valM
W_dstE  out  REG_W  writeback dstE (NONE_REG when invalid)
W_dstM  out  REG_W  writeback dstM (NONE_REG when invalid)
fwd_src  in  REG_W  register queried by decode
fwd_hit  out  1  some valid in-flight slot will write fwd_src
fwd_val  out  DATA_W  value to forward (0 when fwd_hit=0)

Behaviour:
- Slot contents: {valid, valE, valM, dstE, dstM}. A NOP is {0, 0, 0, NONE_REG, NONE_REG}.
- Reset: while rst=1, every slot is forced to NOP immediately, regardless of clk. After reset: W_valid=0, W_valE=0, W_valM=0, W_dstE=W_dstM=NONE_REG, fwd_hit=0, fwd_val=0.
- Each rising edge, with rst=0, priority order:
  - stall=1: all slots hold. stall overrides bubble and in_valid.
  - else bubble=1: slot 0 <= NOP; slot i <= slot i-1 for i>=1.
  - else in_valid=1: slot 0 <= {1, M_valE, m_valM, M_dstE, M_dstM}; others shift.
  - else (in_valid=0): slot 0 <= NOP; others shift.
- Latency: data presented at edge n appears on W_* after edge n+DEPTH-1, i.e. DEPTH edges of capture/shift. With DEPTH=1 it behaves exactly as the single-stage register.
- A slot carries its dst fields unmodified. A valid slot may have dstE/dstM = NONE_REG, meaning that port performs no write.
- W_* outputs are registered directly from slot DEPTH-1, with no combinational path from the inputs.
- Forwarding is combinational over slots only, not over the M inputs:
  - fwd_src==NONE_REG: fwd_hit=0, fwd_val=0.
  - Search slot 0 (youngest) to slot DEPTH-1 (oldest). The first valid slot with dstM==fwd_src or dstE==fwd_src wins.
  - Within a slot, a dstM match beats a dstE match, so load data wins.
  - Invalid slots never match.
- DEPTH outside 1..4 is a fatal elaboration error.

Test Plan:
- Reset: rst=1 mid-simulation (asynchronous, no clock edge) with slots full -> W_valid=0, W_valE=0, W_dstE=0, fwd_hit=0 immediately.
- DEPTH=1 streaming: in_valid=1, inputs 1,2,...,7 on successive edges -> W_valE/W_valM/W_dstE/W_dstM equal k one edge after k is presented, W_valid=1.
- DEPTH=3 latency: apply valE=0xA5 at edge 0, then in_valid=0 -> W_valE=0xA5 and W_valid=1 after edge 2 only; then W_valid=0 after edge 3.
- Stall/bubble priority: stall=1 and bubble=1 together for 2 edges -> outputs unchanged. Then bubble=1 alone -> slot 0 becomes NOP, and W_dstE=NONE_REG once it reaches W.
- Forwarding priority (DEPTH=3): slot0 {dstE=5, valE=0x11}, slot1 {dstM=5, valM=0x22}, fwd_src=5 -> fwd_hit=1, fwd_val=0x11. Same slot with dstE=dstM=5, valE=0x33, valM=0x44 -> fwd_val=0x44.
- Forwarding exclusions: fwd_src=0 with slots carrying dst 0 -> fwd_hit=0. A matching slot with valid=0 (bubble) -> fwd_hit=0, fwd_val=0.
